mux_8_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_8_1_rr_arbiter
// PURPOSE
//  Shares one 8:1 bit mux between 8 requesters. A round-robin arbiter grants one requester
//   at a time and drives the mux selects S2..S0 from the grant.
//  Output is a registered sample of the selected data bit, with a valid flag.
//  Sits in front of mux_8_1; the arbiter and mux together are the unit checked against
//   the post-route netlist.
// PARAMETERS
//  NUM_REQ   8   requester count; fixed at 8 (3 select bits). Other values are illegal.
//  MAX_HOLD  4   max consecutive cycles one grant is held; legal range 1..255.
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous reset, active low
//  req        in   8  request per requester; bit i = requester i
//  D          in   8  data bit per requester; D[i] feeds mux input Di
//  grant      out  8  one-hot grant, registered; all-zero when idle
//  S0,S1,S2   out  1  mux selects = binary index of the granted requester (S0 = LSB), registered
//  out        out  1  registered sample of D[{S2,S1,S0}]
//  out_valid  out  1  high when out holds a granted sample
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, grant=0, S=0, out=0, out_valid=0,
//   ptr=0, hold_cnt=0.
//  Priority: the rotating encoder scans req from ptr upward, wrapping 7->0. The first set
//   bit wins.
//  IDLE, req==0: stay in IDLE; grant=0.
//  IDLE, req!=0: at the next edge, grant=onehot(win), S=win, hold_cnt=0, state goes to GRANT.
//  GRANT, each edge: out<=D[S]; out_valid<=1; hold_cnt<=hold_cnt+1 (8-bit saturating).
//  Release occurs when either:
//   - req[S]==0 at the edge (requester dropped), or
//   - hold_cnt==MAX_HOLD-1 (hold time expired).
//  On release:
//   - ptr<=S+1 mod 8.
//   - Re-arbitration uses the new ptr in the same cycle: a winner is granted directly with
//     no idle bubble.
//   - If no requester wins, state goes to IDLE, grant=0, S holds its last value.
//  Expired holder still requesting: it becomes lowest priority. If it is the only
//   requester, it is re-granted with hold_cnt=0.
//  out_valid:
//   - Goes to 0 on the edge after entering IDLE.
//   - out holds its last value while out_valid=0.
//  Latency: req rises at edge N (seen in IDLE) -> grant/S at N+1 -> out/out_valid at N+2.
//  Simultaneous release and new requests: the winner is chosen from the req value present
//   at that edge. A newly arriving req and a pending req are treated alike.
//  D changes mid-grant: out follows D[S] with 1 cycle of latency. No handshake on D.
//  Reset mid-grant: grant, S and outputs clear immediately (asynchronously); ptr returns to 0.
//  Invariant: grant is one-hot or zero, and grant==onehot({S2,S1,S0}) whenever grant!=0.
// STRUCTURE
//  Package mux_8_1_pkg:
//   - NUM_REQ=8, SEL_W=3.
//   - typedef enum logic {IDLE, GRANT} arb_state_t.
//   - typedef logic [SEL_W-1:0] sel_t.
//  Sub-module mux_8_1_rr_picker: combinational rotating-priority encoder.
//   - Inputs: req[7:0], ptr(sel_t).
//   - Outputs: any, win(sel_t).
//  Top level: state register, ptr/hold counters, output registers. The actual data select
//   is D[S] inside this block; a mux_8_1 instance may be used instead.
// TESTING
//  1 Reset: rst_n=0 mid-run -> grant=0, S=0, out=0, out_valid=0 immediately, asynchronously.
//  2 req=8'h08, D=8'hAA held 3 cycles, then dropped:
//    - grant=8'h08 and S=3'b011 one cycle after req;
//    - out=1, out_valid=1 one cycle later;
//    - IDLE after the drop.
//  3 req=8'hFF, MAX_HOLD=4: grants run 0,1,...,7,0, each exactly 4 cycles, with no gap
//    cycles (grant never 0).
//  4 ptr=7, req=8'h81: requester 7 is granted first. At its release, requester 0 is granted
//    next (wrap-around).
//  5 Only req[2] high for 10 cycles, MAX_HOLD=4: requester 2 is re-granted each 4 cycles,
//    hold_cnt restarts, out_valid stays 1.
//  6 Random req/D for 2000 cycles:
//    - out == golden mux_8_1(D, S delayed 1) whenever out_valid=1;
//    - grant is one-hot/zero at all times;
//    - no requester waits longer than 7*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/mux_8_1_pkg.sv
// Shared constants, types and helpers for the round-robin-arbitrated 8:1 mux.
package mux_8_1_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_REQ-1:0] onehot(input sel_t idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_8_1_rr_picker.sv
// Combinational rotating-priority encoder: first set request at or above ptr wins,
// wrapping from requester 7 back to requester 0.
module mux_8_1_rr_picker
  import mux_8_1_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               any,
  output sel_t               win
);

  // Scan from the farthest offset back toward ptr so the nearest set bit is written last.
  always_comb begin
    sel_t idx_s;
    any   = |req;
    win   = ptr;
    idx_s = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s = ptr + sel_t'(i);
      if (req[idx_s]) begin
        win = idx_s;
      end else begin
        win = win;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux between 8 requesters; grant, selects
// and the sampled data bit are all registered.
module mux_8_1_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] D,
  output logic [NUM_REQ-1:0] grant,
  output logic               S0,
  output logic               S1,
  output logic               S2,
  output logic               out,
  output logic               out_valid
);
  import mux_8_1_pkg::*;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t         state_r, state_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  sel_t               sel_r, sel_nxt_s;
  sel_t               ptr_r, ptr_nxt_s;
  logic [7:0]         hold_cnt_r, hold_cnt_nxt_s;
  logic               out_r, out_nxt_s;
  logic               out_valid_r, out_valid_nxt_s;

  sel_t       sel_inc_s, pick_ptr_s, win_s;
  logic       any_s, release_s;
  logic [7:0] hold_inc_s;

  // While granting, the picker already looks from sel+1 so a release re-arbitrates
  // in the same cycle against the pointer it is about to load.
  assign sel_inc_s  = sel_r + 3'd1;
  assign pick_ptr_s = (state_r == GRANT) ? sel_inc_s : ptr_r;
  assign hold_inc_s = (hold_cnt_r == 8'hFF) ? 8'hFF : hold_cnt_r + 8'd1;
  assign release_s  = (state_r == GRANT) && (!req[sel_r] || (hold_cnt_r == HOLD_LAST));

  mux_8_1_rr_picker u_picker (
    .req (req),
    .ptr (pick_ptr_s),
    .any (any_s),
    .win (win_s)
  );

  // Next-state, grant, counters and output sample.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    sel_nxt_s       = sel_r;
    ptr_nxt_s       = ptr_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    out_nxt_s       = out_r;
    out_valid_nxt_s = out_valid_r;
    case (state_r)
      IDLE: begin
        out_valid_nxt_s = 1'b0;
        if (any_s) begin
          state_nxt_s    = GRANT;
          grant_nxt_s    = onehot(win_s);
          sel_nxt_s      = win_s;
          hold_cnt_nxt_s = 8'd0;
        end else begin
          grant_nxt_s = {NUM_REQ{1'b0}};
        end
      end
      GRANT: begin
        out_nxt_s       = D[sel_r];
        out_valid_nxt_s = 1'b1;
        hold_cnt_nxt_s  = hold_inc_s;
        if (release_s) begin
          ptr_nxt_s = sel_inc_s;
          if (any_s) begin
            grant_nxt_s    = onehot(win_s);
            sel_nxt_s      = win_s;
            hold_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s    = IDLE;
            grant_nxt_s    = {NUM_REQ{1'b0}};
            hold_cnt_nxt_s = 8'd0;
          end
        end else begin
          ptr_nxt_s = ptr_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        grant_nxt_s     = {NUM_REQ{1'b0}};
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= {NUM_REQ{1'b0}};
      sel_r       <= 3'd0;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= 8'd0;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      sel_r       <= sel_nxt_s;
      ptr_r       <= ptr_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      out_r       <= out_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign grant     = grant_r;
  assign S0        = sel_r[0];
  assign S1        = sel_r[1];
  assign S2        = sel_r[2];
  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
// Self-checking bench for mux_8_1_rr_arbiter: directed vector table, hand sequences
// for reset, rotation, wrap and hold expiry, then a constrained-random run.
module tb_mux_8_1_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int WAIT_MAX = 7 * MAX_HOLD + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] D;
  logic [7:0] grant;
  logic       S0, S1, S2, out, out_valid;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       out;
    logic       valid;
  } vec_t;

  vec_t tbl[14];
  int   wait_cnt[8];

  mux_8_1_rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .D         (D),
    .grant     (grant),
    .S0        (S0),
    .S1        (S1),
    .S2        (S2),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eg, input logic [2:0] es,
                           input logic eo, input logic ev);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".sel"}, 8'({S2, S1, S0}), 8'(es));
    check({tag, ".out"}, 8'(out), 8'(eo));
    check({tag, ".valid"}, 8'(out_valid), 8'(ev));
  endtask

  initial begin
    logic [7:0] prev_d, prev_grant;
    logic [2:0] prev_sel;
    logic [2:0] exp_idx;

    // {req, D, expected grant, S, out, out_valid} after each edge, from reset (ptr=0)
    tbl[0]  = '{8'h08, 8'hAA, 8'h08, 3'd3, 1'b0, 1'b0};
    tbl[1]  = '{8'h08, 8'hAA, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[2]  = '{8'h08, 8'hAA, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[3]  = '{8'h00, 8'hAA, 8'h00, 3'd3, 1'b1, 1'b1};
    tbl[4]  = '{8'h00, 8'hAA, 8'h00, 3'd3, 1'b1, 1'b0};
    tbl[5]  = '{8'h40, 8'h00, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 8'h00, 3'd6, 1'b0, 1'b1};
    tbl[7]  = '{8'h81, 8'h81, 8'h80, 3'd7, 1'b0, 1'b0};
    tbl[8]  = '{8'h81, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
    tbl[9]  = '{8'h81, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
    tbl[10] = '{8'h81, 8'h01, 8'h80, 3'd7, 1'b0, 1'b1};
    tbl[11] = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1};
    tbl[12] = '{8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 1'b1};
    tbl[13] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req   = 8'h00;
    D     = 8'h00;
    repeat (2) @(posedge clk);
    #1 check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req = tbl[i].req;
      D   = tbl[i].d;
      @(posedge clk);
      #1 check_all($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].out, tbl[i].valid);
    end

    // Asynchronous reset in the middle of a grant (ptr=1 here, so requester 1 wins)
    @(negedge clk);
    req = 8'hFF;
    D   = 8'hFF;
    @(posedge clk);
    #1 check("pre_rst.grant", grant, 8'h02);
    @(posedge clk);
    #1 check("pre_rst.valid", 8'(out_valid), 8'd1);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // All requesting: 0..7,0 each held exactly MAX_HOLD cycles, no gaps
    for (int e = 0; e < 9 * MAX_HOLD; e++) begin
      @(posedge clk);
      exp_idx = 3'((e / MAX_HOLD) % 8);
      #1;
      check($sformatf("rot%0d.grant", e), grant, 8'h01 << exp_idx);
      check($sformatf("rot%0d.sel", e), 8'({S2, S1, S0}), 8'(exp_idx));
    end

    // Sole requester 2 is re-granted on every expiry without a gap
    @(negedge clk) req = 8'h04;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1 check_all($sformatf("solo%0d", e), 8'h04, 3'd2, 1'b1, 1'b1);
    end
    // hold restarted at the last re-grant: two more cycles, then requester 5 takes over
    @(negedge clk) req = 8'h24;
    @(posedge clk);
    #1 check("solo_hold_a", grant, 8'h04);
    @(posedge clk);
    #1 check("solo_hold_b", grant, 8'h04);
    @(posedge clk);
    #1 check("solo_handoff", grant, 8'h20);

    // Constrained random: requesters keep req until served, then may drop
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (req[i] && grant[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end else begin
          req[i] = 1'b1;
        end
      end
      D          = 8'($urandom);
      prev_d     = D;
      prev_sel   = {S2, S1, S0};
      prev_grant = grant;
      @(posedge clk);
      #1;
      check("rnd.onehot0", 8'($onehot0(grant)), 8'd1);
      if (grant != 8'h00) begin
        check("rnd.grant_sel", grant, 8'h01 << {S2, S1, S0});
      end
      check("rnd.valid", 8'(out_valid), 8'(prev_grant != 8'h00));
      if (out_valid) begin
        check("rnd.out", 8'(out), 8'(prev_d[prev_sel]));
      end
      for (int i = 0; i < 8; i++) begin
        if (grant[i]) begin
          wait_cnt[i] = 0;
        end else if (req[i]) begin
          wait_cnt[i]++;
        end
        if (wait_cnt[i] > WAIT_MAX) begin
          check($sformatf("rnd.starve%0d", i), 8'(wait_cnt[i]), 8'(WAIT_MAX));
          wait_cnt[i] = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
